mhz1_bus_responder: RTL
=======================

Name: mhz1_bus_responder

Overview:
- Responder side of the 1 MHz bus stretch protocol, sitting between the CPU and the slow peripherals (FRED/JIM/SHEILA: VIAs, ACIA, ADC, user port).
- Decodes CPU addresses in the slow range and raises mhz1_enable so the clock-enable generator masks CPU cycles.
- Runs exactly one 1 MHz peripheral access, aligned to the 1 MHz phase, with latched address, control and write data.
- Captures read data on the closing mhz1_clken and holds it for the CPU's completing cpu_clken.

Parameters:
- SLOW_PAGE_LO, 8'hFC, lowest address high byte treated as 1 MHz space.
- SLOW_PAGE_HI, 8'hFE, highest address high byte treated as 1 MHz space.
- FAST_LO, 8'h20, first SHEILA (page FE) low byte exempt from stretching (2 MHz devices).
- FAST_HI, 8'h3F, last exempt SHEILA low byte.

Ports:
- clk_48m  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cpu_clken  in  1  CPU cycle completes this clock.
- mhz2_clken  in  1  pulse at 48 MHz phase 23 and 47.
- mhz1_clken  in  1  pulse at phase 47; end of each 1 MHz cycle.
- cpu_a  in  16  CPU address, stable from one cpu_clken to the next.
- cpu_rnw  in  1  1 = read.
- cpu_dout  in  8  CPU write data, valid with address.
- slow_din  in  8  peripheral read data.
- mhz1_enable  out  1  stretch request to the clock-enable generator.
- slow_cs  out  1  peripheral access active.
- slow_a  out  16  latched address.
- slow_rnw  out  1  latched direction.
- slow_dout  out  8  latched write data.
- slow_phase2  out  1  1 MHz phase-2 window of the access.
- slow_strobe  out  1  one-clock pulse; peripheral commits write / read data sampled.
- slow_rdata  out  8  captured read data, held until the next read capture.

Behaviour:
- hit = (cpu_a[15:8] in SLOW_PAGE_LO..SLOW_PAGE_HI) and not (cpu_a[15:8]==8'hFE and cpu_a[7:0] in FAST_LO..FAST_HI).
- mhz1_enable = hit and state==IDLE. Combinational, no latency; it must be valid at phase 23/47 ahead of cpu_cycle 24/0.
- States: IDLE, ACCESS, HOLD.
- IDLE:
  - Leaves on the first mhz2_clken with hit=1 and goes to ACCESS.
  - On that edge, latches slow_a, slow_rnw and slow_dout (cpu_dout).
  - slow_phase2 <= ~mhz1_clken: entry at phase 23 starts already in phase 2; entry at phase 47 starts in phase 1.
- ACCESS:
  - slow_cs = 1.
  - A mhz2_clken without mhz1_clken sets slow_phase2.
  - The first mhz1_clken strictly after entry ends the access:
    - slow_strobe = 1 for that clock.
    - If slow_rnw, slow_rdata <= slow_din on that edge.
    - slow_cs and slow_phase2 clear on that edge; next state HOLD.
- Duration: entry at phase 47 gives ACCESS of 48 clocks; entry at phase 23 gives 24 clocks.
- HOLD:
  - slow_cs = 0, mhz1_enable = 0.
  - Exits to IDLE on cpu_clken, normally the next clock, at phase 0.
  - No other exit except reset.
- Simultaneous events:
  - In IDLE at phase 47 (mhz1_clken and mhz2_clken together), entry wins. That mhz1_clken does not close the access.
  - cpu_clken in IDLE or ACCESS is ignored.
- Strobe is combinational from state==ACCESS and mhz1_clken. All other outputs are registered.
- Reset (any state, including mid-ACCESS):
  - state=IDLE.
  - slow_cs, slow_phase2, slow_strobe, slow_rnw = 0.
  - slow_a = 16'h0000, slow_dout = 8'h00, slow_rdata = 8'h00.
  - No strobe is issued for an aborted access.
- A write cycle never modifies slow_rdata.
- Back-to-back slow accesses: a new hit is seen only after HOLD→IDLE. The next access starts at the following mhz2_clken, phase 23 at earliest.

Test Plan:
- Read FE40 (VIA) presented after cpu_clken at phase 0, slow_din=8'h5A:
  - mhz1_enable high.
  - ACCESS entered at phase 23 with slow_phase2=1.
  - slow_strobe at phase 47.
  - slow_rdata=8'h5A.
  - HOLD→IDLE at phase 0.
- Write 8'hC3 to FC10 presented at phase 24:
  - ACCESS entered at phase 47 with slow_phase2=0.
  - slow_phase2 rises after phase 23.
  - Strobe at phase 47, 48 clocks after entry.
  - slow_dout=8'hC3, slow_rnw=0.
  - slow_rdata unchanged.
- Address FE30 (exempt) and 8000:
  - mhz1_enable never asserts.
  - slow_cs stays 0 for 96 clocks.
- Consecutive reads FE60 then FE61:
  - Two separate ACCESS windows, two strobes.
  - mhz1_enable low throughout HOLD.
- reset_n low at phase 30 of ACCESS:
  - Next clock all outputs at reset values.
  - No strobe at phase 47.
  - mhz1_enable follows hit again once reset releases.
- Phase-47 entry coincidence:
  - Verify no strobe on the entry clock.
  - Strobe exactly one 1 MHz period later.

Source files
------------

// File: rtl/mhz1_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mhz1_bus_responder
//  Purpose  : Responder side of the 1 MHz bus stretch protocol. It decodes
//             CPU addresses in the slow peripheral space (FRED/JIM/SHEILA,
//             minus the 2 MHz SHEILA window) and requests a CPU stretch. It
//             then runs exactly one 1 MHz peripheral access, aligned to the
//             1 MHz phase, using a latched address, direction and write data.
//             Read data is captured on the closing mhz1_clken and held for
//             the CPU's completing cpu_clken.
//  Ports    : clk_48m      - system clock
//             reset_n      - synchronous active-low reset
//             cpu_clken    - CPU cycle completes this clock
//             mhz2_clken   - 2 MHz phase pulse (48 MHz phase 23 and 47)
//             mhz1_clken   - 1 MHz end-of-cycle pulse (phase 47)
//             cpu_a/cpu_rnw/cpu_dout - CPU address, direction, write data
//             slow_din     - peripheral read data
//             mhz1_enable  - stretch request (combinational)
//             slow_cs/slow_a/slow_rnw/slow_dout/slow_phase2 - access bus
//             slow_strobe  - commit/sample pulse (combinational)
//             slow_rdata   - captured read data
//  Revision : 1.0  initial release
// ============================================================================
module mhz1_bus_responder #(
    parameter logic [7:0] SLOW_PAGE_LO = 8'hFC,
    parameter logic [7:0] SLOW_PAGE_HI = 8'hFE,
    parameter logic [7:0] FAST_LO      = 8'h20,
    parameter logic [7:0] FAST_HI      = 8'h3F
) (
    input  logic        clk_48m,
    input  logic        reset_n,
    input  logic        cpu_clken,
    input  logic        mhz2_clken,
    input  logic        mhz1_clken,
    input  logic [15:0] cpu_a,
    input  logic        cpu_rnw,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  slow_din,
    output logic        mhz1_enable,
    output logic        slow_cs,
    output logic [15:0] slow_a,
    output logic        slow_rnw,
    output logic [7:0]  slow_dout,
    output logic        slow_phase2,
    output logic        slow_strobe,
    output logic [7:0]  slow_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_slow_cs;
    logic [15:0] r_slow_a;
    logic        r_slow_rnw;
    logic [7:0]  r_slow_dout;
    logic        r_slow_phase2;
    logic [7:0]  r_slow_rdata;

    logic        w_page_slow;
    logic        w_fast_exempt;
    logic        w_hit;

    assign w_page_slow   = (cpu_a[15:8] >= SLOW_PAGE_LO) && (cpu_a[15:8] <= SLOW_PAGE_HI);
    assign w_fast_exempt = (cpu_a[15:8] == 8'hFE) &&
                           (cpu_a[7:0] >= FAST_LO) && (cpu_a[7:0] <= FAST_HI);
    assign w_hit         = w_page_slow && !w_fast_exempt;

    // Must be valid before the clock-enable generator samples it at phase
    // 23/47, so no register stage here.
    assign mhz1_enable = w_hit && (r_state == ST_IDLE);

    // In IDLE a coincident mhz1_clken is the entry edge, not a close; only
    // ACCESS can produce the strobe.
    assign slow_strobe = (r_state == ST_ACCESS) && mhz1_clken;

    always_ff @(posedge clk_48m) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_slow_cs     <= 1'b0;
            r_slow_a      <= 16'h0000;
            r_slow_rnw    <= 1'b0;
            r_slow_dout   <= 8'h00;
            r_slow_phase2 <= 1'b0;
            r_slow_rdata  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mhz2_clken && w_hit) begin
                        r_state       <= ST_ACCESS;
                        r_slow_cs     <= 1'b1;
                        r_slow_a      <= cpu_a;
                        r_slow_rnw    <= cpu_rnw;
                        r_slow_dout   <= cpu_dout;
                        // Entering at phase 23 lands mid-cycle (phase 2);
                        // entering at phase 47 starts a fresh phase 1.
                        r_slow_phase2 <= ~mhz1_clken;
                    end
                end
                ST_ACCESS: begin
                    if (mhz1_clken) begin
                        if (r_slow_rnw) begin
                            r_slow_rdata <= slow_din;
                        end
                        r_slow_cs     <= 1'b0;
                        r_slow_phase2 <= 1'b0;
                        r_state       <= ST_HOLD;
                    end else if (mhz2_clken) begin
                        r_slow_phase2 <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Wait for the stretched CPU cycle to complete so the
                    // same address is not decoded as a fresh hit.
                    if (cpu_clken) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign slow_cs     = r_slow_cs;
    assign slow_a      = r_slow_a;
    assign slow_rnw    = r_slow_rnw;
    assign slow_dout   = r_slow_dout;
    assign slow_phase2 = r_slow_phase2;
    assign slow_rdata  = r_slow_rdata;

endmodule
`default_nettype wire
